// File: rtl/spu_pkg.sv
// Shared SPU fetch types and constants: no-op encodings and the buffered instruction pair.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package spu_pkg;

    // Local-store byte address width carried in each buffered pair
    localparam int SPU_ADDR_W = 18;

    // Even-pipe and odd-pipe no-ops shown when no real pair is available
    localparam logic [31:0] SPU_NOP  = 32'h4020_0000;
    localparam logic [31:0] SPU_LNOP = 32'h0020_0000;

    // One fetched doubleword split into its two instruction slots
    typedef struct packed {
        logic [31:0]           i1;
        logic [31:0]           i2;
        logic [SPU_ADDR_W-1:0] pc;
    } fetch_pair_t;

endpackage

// File: rtl/pair_fifo.sv
// Synchronous FIFO of generic element type with clear, count, empty, full and head.
// Latency: a pushed element is visible at the head one cycle after the push edge.
// Backpressure: a push into a full FIFO is accepted only together with a pop.
module pair_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  T                       push_data,
    output T                       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Element storage; contents are meaningless while the FIFO is empty, so no reset
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; clear empties the FIFO at the edge
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Dual-issue fetch: credit-limited doubleword requests into a pair buffer feeding IF/ID.
// Latency: request to valid_IF is memory latency + 1 cycle; redirect to new request is 1 cycle.
// Backpressure: stall holds the head pair; requests stop once buffered + in-flight pairs fill the buffer.
module fetch_unit
    import spu_pkg::*;
#(
    parameter int                ADDR_W    = 18,
    parameter int                BUF_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [63:0]       mem_rdata,
    output logic [31:0]       instruction1_IF,
    output logic [31:0]       instruction2_IF,
    output logic [ADDR_W-1:0] pc_IF,
    output logic              valid_IF
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [ADDR_W-1:0] fpc;          // next address to request
    logic [ADDR_W-1:0] rpc;          // address of the next response that will be kept
    logic [CW-1:0]     outstanding;  // accepted requests not yet answered
    logic [CW-1:0]     discard;      // answers still owed to a flushed stream
    logic              odd_pending;  // first kept pair after an odd-word redirect
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CW:0]       credit_used;
    logic [ADDR_W-1:0] target;
    logic              accept;
    logic              push;
    logic              pop;
    logic              unused_low_bits;
    fetch_pair_t       push_pair;
    fetch_pair_t       head_pair;

    assign target          = {redirect_pc[ADDR_W-1:3], 3'b000};
    assign unused_low_bits = ^redirect_pc[1:0];

    // Every in-flight request owns a buffer slot, so the buffer can never overflow
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    assign mem_req     = !reset && !redirect && !fifo_full && (credit_used < (CW+1)'(BUF_DEPTH));
    assign mem_addr    = fpc;
    assign accept      = mem_req && mem_ready;

    // A response in the redirect cycle belongs to the old stream and is always dropped
    assign push = mem_rvalid && !reset && !redirect && (discard == '0);
    assign pop  = !stall && !fifo_empty && !redirect;

    assign push_pair.i1 = odd_pending ? SPU_NOP : mem_rdata[63:32];
    assign push_pair.i2 = mem_rdata[31:0];
    assign push_pair.pc = SPU_ADDR_W'(rpc);

    pair_fifo #(
        .DEPTH (BUF_DEPTH),
        .T     (fetch_pair_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .clear     (redirect),
        .push_data (push_pair),
        .head      (head_pair),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Track in-flight requests and how many of them a redirect has orphaned
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(mem_rvalid);
            if (redirect) begin
                discard <= outstanding - CW'(mem_rvalid);
            end else if (mem_rvalid && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
        end
    end

    // Request/response address pointers and the odd-target one-shot
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc         <= RESET_PC;
            rpc         <= RESET_PC;
            odd_pending <= 1'b0;
        end else if (redirect) begin
            fpc         <= target;
            rpc         <= target;
            odd_pending <= redirect_pc[2];
        end else begin
            if (accept) fpc <= fpc + ADDR_W'(8);
            if (push) begin
                rpc         <= rpc + ADDR_W'(8);
                odd_pending <= 1'b0;
            end
        end
    end

    // Present the head pair, or a NOP/LNOP bubble when nothing real is buffered
    always_comb begin
        instruction1_IF = SPU_NOP;
        instruction2_IF = SPU_LNOP;
        pc_IF           = fpc;
        valid_IF        = 1'b0;
        if (!reset && !fifo_empty) begin
            instruction1_IF = head_pair.i1;
            instruction2_IF = head_pair.i2;
            pc_IF           = ADDR_W'(head_pair.pc);
            valid_IF        = 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable in-order memory model.
// Latency: memory answers each accepted request 'lat' cycles later, in order.
// Backpressure: stall and mem_ready are driven directly by the directed sequence.
module tb_fetch_unit;
    localparam int          AW   = 18;
    localparam logic [31:0] NOP  = 32'h4020_0000;
    localparam logic [31:0] LNOP = 32'h0020_0000;

    logic          clk;
    logic          reset;
    logic          stall;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [63:0]   mem_rdata;
    logic [31:0]   instruction1_IF;
    logic [31:0]   instruction2_IF;
    logic [AW-1:0] pc_IF;
    logic          valid_IF;

    typedef struct {
        logic [AW-1:0] a;
        int            due;
    } mreq_t;

    mreq_t mq[$];
    int    cyc;
    int    lat;
    int    acc;
    int    pops;
    int    n_checks;
    int    n_pass;
    int    n;

    fetch_unit #(
        .ADDR_W    (AW),
        .BUF_DEPTH (4),
        .RESET_PC  ('0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ready       (mem_ready),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .instruction1_IF (instruction1_IF),
        .instruction2_IF (instruction2_IF),
        .pc_IF           (pc_IF),
        .valid_IF        (valid_IF)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic settle();
        #1;
    endtask

    // Sample this cycle's handshakes, cross the edge, drive next cycle's response
    task automatic tick();
        mreq_t r;
        #1;
        if (reset) begin
            mq.delete();
        end else if (mem_req && mem_ready) begin
            r.a   = mem_addr;
            r.due = cyc + lat;
            mq.push_back(r);
            acc++;
        end
        if (valid_IF && !stall && !redirect && !reset) pops++;
        @(posedge clk);
        #1;
        cyc++;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = {32'(mq[0].a), 32'(mq[0].a) + 32'd4};
            void'(mq.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic wait_valid(input int max, output int waited);
        waited = 0;
        while (!valid_IF && waited < max) begin
            tick();
            waited++;
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; lat = 1; acc = 0; pops = 0;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_req", mem_req, 0);
        chk("rst_valid", valid_IF, 0);
        chk("rst_i1", instruction1_IF, NOP);
        chk("rst_i2", instruction2_IF, LNOP);

        // Reset release and 1-cycle streaming
        reset = 1'b0; acc = 0; pops = 0;
        settle();
        chk("first_req", mem_req, 1);
        chk("first_addr", mem_addr, 0);
        tick();
        chk("c1_valid", valid_IF, 0);
        chk("c1_addr", mem_addr, 8);
        tick();
        chk("c2_valid", valid_IF, 1);
        chk("c2_pc", pc_IF, 0);
        chk("c2_i1", instruction1_IF, 0);
        chk("c2_i2", instruction2_IF, 4);
        tick();
        chk("c3_pc", pc_IF, 8);
        chk("c3_i1", instruction1_IF, 8);
        chk("c3_i2", instruction2_IF, 32'hC);
        tick();
        chk("c4_pc", pc_IF, 32'h10);
        chk("c4_i2", instruction2_IF, 32'h14);

        // Stall backpressure: head frozen, buffer plus in-flight saturates at 4
        stall = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("stall_valid", valid_IF, 1);
            chk("stall_pc", pc_IF, pops * 8);
            tick();
        end
        chk("stall_occ_le4", ((acc - pops) <= 4), 1);
        chk("stall_occ", acc - pops, 4);
        stall = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("rel_valid", valid_IF, 1);
            chk("rel_pc", pc_IF, pops * 8);
            chk("rel_i1", instruction1_IF, pops * 8);
            tick();
        end

        // Redirect with two in-flight responses under 3-cycle memory latency
        redirect = 1'b1; redirect_pc = 18'h40; lat = 3;
        settle();
        chk("rd_noreq", mem_req, 0);
        tick();
        redirect = 1'b0;
        settle();
        chk("rd_req40", mem_req, 1);
        chk("rd_addr40", mem_addr, 18'h40);
        tick();
        tick();
        redirect = 1'b1; redirect_pc = 18'h100;
        tick();
        redirect = 1'b0;
        settle();
        chk("rd_addr100", mem_addr, 18'h100);
        chk("rd_empty", valid_IF, 0);
        wait_valid(20, n);
        chk("rd_valid", valid_IF, 1);
        chk("rd_lat", n, 4);
        chk("rd_pc", pc_IF, 18'h100);
        chk("rd_i1", instruction1_IF, 32'h100);
        chk("rd_i2", instruction2_IF, 32'h104);

        // Odd-word target
        redirect = 1'b1; redirect_pc = 18'h204; lat = 1;
        tick();
        redirect = 1'b0;
        wait_valid(30, n);
        chk("odd_valid", valid_IF, 1);
        chk("odd_i1", instruction1_IF, NOP);
        chk("odd_i2", instruction2_IF, 32'h204);
        chk("odd_pc", pc_IF, 18'h200);
        tick();
        wait_valid(30, n);
        chk("odd2_valid", valid_IF, 1);
        chk("odd2_pc", pc_IF, 18'h208);
        chk("odd2_i1", instruction1_IF, 32'h208);
        chk("odd2_i2", instruction2_IF, 32'h20C);

        // Redirect coinciding with a response, then memory not ready for 5 cycles
        repeat (6) tick();
        for (int k = 0; k < 10 && !mem_rvalid; k++) tick();
        redirect = 1'b1; redirect_pc = 18'h300; mem_ready = 1'b0;
        tick();
        redirect = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("sim_req", mem_req, 1);
            chk("sim_addr", mem_addr, 18'h300);
            chk("sim_valid", valid_IF, 0);
            chk("sim_i1", instruction1_IF, NOP);
            chk("sim_i2", instruction2_IF, LNOP);
            tick();
        end
        mem_ready = 1'b1;
        wait_valid(20, n);
        chk("sim_post_valid", valid_IF, 1);
        chk("sim_post_pc", pc_IF, 18'h300);

        // Fetch address wraps at the top of local store
        redirect = 1'b1; redirect_pc = 18'h3FFF8;
        tick();
        redirect = 1'b0;
        settle();
        chk("wrap_addr_top", mem_addr, 18'h3FFF8);
        tick();
        chk("wrap_addr_zero", mem_addr, 0);
        wait_valid(20, n);
        chk("wrap_pc_top", pc_IF, 18'h3FFF8);
        tick();
        wait_valid(20, n);
        chk("wrap_valid0", valid_IF, 1);
        chk("wrap_pc0", pc_IF, 0);
        chk("wrap_i2", instruction2_IF, 4);

        // Reset in mid-stream restores the reset state
        reset = 1'b1;
        tick();
        tick();
        chk("mrst_req", mem_req, 0);
        chk("mrst_valid", valid_IF, 0);
        chk("mrst_i1", instruction1_IF, NOP);
        reset = 1'b0;
        settle();
        chk("mrst_req_after", mem_req, 1);
        chk("mrst_addr", mem_addr, 0);
        wait_valid(20, n);
        chk("mrst_first_valid", valid_IF, 1);
        chk("mrst_first_pc", pc_IF, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Dual-issue instruction fetch stage for the SPU pipeline. Each accepted local-store request returns one 8-byte-aligned doubleword, which the block splits into an instruction pair. Pairs are held in a small prefetch buffer and presented to the IF/ID pipeline register as `instruction1_IF` / `instruction2_IF`. The block handles decode backpressure (`stall`), branch redirects with in-flight response discard, and odd-word branch targets.

## Interface
Parameters:
- `ADDR_W`, default 18: local-store byte address width.
- `BUF_DEPTH`, default 4: prefetch buffer depth in instruction pairs; must be a power of 2, ≥ 2.
- `RESET_PC`, default 0: fetch address after reset; 8-byte aligned.

Ports:
- `clk` in, 1: clock.
- `reset` in, 1: synchronous, active-high.
- `stall` in, 1: downstream cannot accept a pair this cycle.
- `redirect` in, 1: branch taken or flush; restart fetch at `redirect_pc`.
- `redirect_pc` in, ADDR_W: target byte address; bits [1:0] are ignored.
- `mem_req` out, 1: fetch request valid.
- `mem_addr` out, ADDR_W: doubleword address; bits [2:0] are always 0.
- `mem_ready` in, 1: the request is accepted when `mem_req & mem_ready`.
- `mem_rvalid` in, 1: response valid; responses return in order, at least 1 cycle after acceptance.
- `mem_rdata` in, 64: [63:32] is the word at `mem_addr`, [31:0] is the word at `mem_addr+4`.
- `instruction1_IF` out, 32: even-slot instruction.
- `instruction2_IF` out, 32: odd-slot instruction.
- `pc_IF` out, ADDR_W: address of the doubleword shown on the outputs.
- `valid_IF` out, 1: the outputs carry a real pair.

## Operation
- **Fetch PC** (`fpc`): reset to `RESET_PC`. Advances by 8 on every accepted request. On `redirect`, loads `{redirect_pc[ADDR_W-1:3], 3'b000}` and wraps modulo 2^ADDR_W.
- **Credit rule**: `mem_req` = !reset & !redirect & (fifo_count + outstanding < BUF_DEPTH). The buffer therefore never overflows.
- **Outstanding counter**: +1 on accept, −1 on `mem_rvalid`, with both allowed in the same cycle.
- **Discard counter**: on `redirect`, loads outstanding − (`mem_rvalid` ? 1 : 0). While it is nonzero, each `mem_rvalid` decrements it and the data is dropped. A response in the redirect cycle itself is always dropped.
- **Push**: a non-discarded `mem_rvalid` writes {hi word, lo word, address} into the FIFO.
- **Odd target**: if `redirect_pc[2]` = 1, the first pair pushed after the redirect has instruction1 replaced by `SPU_NOP`. The block holds a one-shot flag for this.
- **Outputs**: combinational from the FIFO head. When the FIFO is empty: `instruction1_IF` = `SPU_NOP` (0x40200000), `instruction2_IF` = `SPU_LNOP` (0x00200000), `valid_IF` = 0, `pc_IF` = `fpc`.
- **Pop**: `!stall & !empty & !redirect`.
- **Redirect**: the FIFO is cleared at the clock edge. Outputs in the redirect cycle are don't-care; the hazard unit flushes IF/ID.
- **Priority**: reset > redirect > push/pop. Simultaneous push and pop on a full FIFO is legal; the count is unchanged.

## Timing
- Reset values: FIFO empty, outstanding = 0, discard = 0, `fpc` = `RESET_PC`. During reset: `mem_req` = 0, `valid_IF` = 0, outputs NOP/LNOP.
- First `mem_req` is in the first cycle with reset low.
- Redirect at cycle T: request to the new target at T+1. With a 1-cycle memory, `rvalid` at T+2 and `valid_IF` = 1 at T+3.
- Steady state with a 1-cycle memory and `mem_ready` = 1: one pair per cycle once the FIFO is non-empty.
- Reset asserted mid-operation clears all state. Responses arriving after reset from pre-reset requests are not tolerated; the memory is reset together with this block.

## Structure
- Shared package `spu_pkg`: `SPU_NOP`, `SPU_LNOP`, and a `fetch_pair_t` struct {`logic [31:0] i1, i2`; `logic [ADDR_W-1:0] pc`}.
- Sub-module `pair_fifo`: synchronous FIFO, parameterised on depth and element type. It provides push, pop, clear, count, empty, full, and head.
- Top level holds `fpc`, the outstanding/discard counters, the odd-target flag and the output mux.

## Test plan
- **Reset and stream**: `RESET_PC` = 0, memory returns `rdata` = {addr, addr+4} with 1-cycle latency. Expect `valid_IF` first at cycle 3 with pair (0x0, 0x4), then 0x8/0xC, 0x10/0x14, one per cycle.
- **Stall backpressure**: hold `stall` for 10 cycles. Expect the outputs frozen, fifo_count + outstanding ≤ 4, no lost or duplicated pair after release.
- **Redirect with in-flight data**: 3-cycle memory latency, 2 requests outstanding, redirect to 0x100. Expect both old responses dropped and the next valid pair at pc 0x100.
- **Odd target**: redirect to 0x204. Expect first pair `instruction1_IF` = 0x40200000, `instruction2_IF` = word at 0x204, `pc_IF` = 0x200; the following pair is 0x208/0x20C.
- **Simultaneous events**: redirect and `mem_rvalid` in the same cycle, with `mem_ready` = 0 for 5 cycles afterwards. Expect the response dropped, `mem_req` held with `mem_addr` stable, outputs NOP/LNOP with `valid_IF` = 0.
- **Wrap**: `fpc` = 2^18 − 8. Expect the next `mem_addr` to be 0.
